// File: rtl/multi_layer_ctrl.sv
// Sequences forward then backward layer enables over a run of samples.
// Optional macro MLC_STALL_EN adds a stall input that freezes progress and masks enables.
module multi_layer_ctrl #(
  parameter int NUM_LAYERS   = 2,
  parameter int PHASE_CYCLES = 4,
  parameter int SAMPLES      = 3,
  parameter int EPOCH_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  TR,
  input  logic                  VL,
  input  logic                  halt,
`ifdef MLC_STALL_EN
  input  logic                  stall,
`endif
  output logic [NUM_LAYERS-1:0] fwd_en,
  output logic [NUM_LAYERS-1:0] bwd_en,
  output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] layer_idx,
  output logic [15:0]           sample_idx,
  output logic [EPOCH_W-1:0]    epoch_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  mode
);

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [LW-1:0] L_LAST  = LW'(NUM_LAYERS - 1);
  localparam logic [15:0]   S_LAST  = 16'(SAMPLES - 1);
  localparam logic [7:0]    PH_LAST = 8'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_t;

  state_t              state, state_n;
  logic [7:0]          phase, phase_n;
  logic [LW-1:0]       layer_n;
  logic [15:0]         sample_n;
  logic [EPOCH_W-1:0]  epoch_n;
  logic                mode_n;
  logic [NUM_LAYERS-1:0] onehot;
  logic                en_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      layer_idx  <= '0;
      sample_idx <= '0;
      epoch_cnt  <= '0;
      mode       <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      layer_idx  <= layer_n;
      sample_idx <= sample_n;
      epoch_cnt  <= epoch_n;
      mode       <= mode_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    layer_n  = layer_idx;
    sample_n = sample_idx;
    epoch_n  = epoch_cnt;
    mode_n   = mode;
    case (state)
      IDLE: begin
        if (!halt && (TR || VL)) begin
          state_n  = FWD;
          mode_n   = TR;
          phase_n  = '0;
          layer_n  = '0;
          sample_n = '0;
        end
      end
      FWD, BWD: begin
        if (halt) begin
          state_n  = IDLE;
          phase_n  = '0;
          layer_n  = '0;
          sample_n = '0;
        end
`ifdef MLC_STALL_EN
        else if (stall) begin
          state_n = state;
        end
`endif
        else if (phase != PH_LAST) begin
          phase_n = phase + 8'd1;
        end else begin
          phase_n = '0;
          if (state == FWD && layer_idx != L_LAST) begin
            layer_n = layer_idx + LW'(1);
          end else if (state == FWD && mode) begin
            state_n = BWD;
          end else if (state == BWD && layer_idx != '0) begin
            layer_n = layer_idx - LW'(1);
          end else if (sample_idx != S_LAST) begin
            // Next sample restarts at layer 0 with no idle cycle in between
            state_n  = FWD;
            layer_n  = '0;
            sample_n = sample_idx + 16'd1;
          end else begin
            state_n = DONE;
            layer_n = '0;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        if (halt) begin
          sample_n = '0;
        end else if (mode) begin
          epoch_n = epoch_cnt + EPOCH_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign onehot = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << layer_idx;
`ifdef MLC_STALL_EN
  assign en_ok = !stall;
`else
  assign en_ok = 1'b1;
`endif

  assign fwd_en = (state == FWD && en_ok) ? onehot : '0;
  assign bwd_en = (state == BWD && en_ok) ? onehot : '0;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_multi_layer_ctrl.sv
// Directed bench for multi_layer_ctrl at NUM_LAYERS=2, PHASE_CYCLES=4, SAMPLES=3.
module tb_multi_layer_ctrl;
  logic       clk = 1'b0;
  logic       rst, TR, VL, halt;
`ifdef MLC_STALL_EN
  logic       stall;
`endif
  logic [1:0] fwd_en, bwd_en;
  logic [0:0] layer_idx;
  logic [15:0] sample_idx;
  logic [7:0] epoch_cnt;
  logic       busy, done, mode;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [1:0] bwd_seen;

  multi_layer_ctrl #(.NUM_LAYERS(2), .PHASE_CYCLES(4), .SAMPLES(3), .EPOCH_W(8)) dut (
    .clk(clk), .rst(rst), .TR(TR), .VL(VL), .halt(halt),
`ifdef MLC_STALL_EN
    .stall(stall),
`endif
    .fwd_en(fwd_en), .bwd_en(bwd_en), .layer_idx(layer_idx), .sample_idx(sample_idx),
    .epoch_cnt(epoch_cnt), .busy(busy), .done(done), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  // Start pulse is sampled at "posedge 0"; the cycle after it is cycle 1.
  task automatic start(input logic tr, input logic vl);
    TR = tr; VL = vl;
    @(posedge clk);
    #1;
    TR = 1'b0; VL = 1'b0;
    cyc = 1;
  endtask

  initial begin
    rst = 1'b1; TR = 1'b0; VL = 1'b0; halt = 1'b0;
`ifdef MLC_STALL_EN
    stall = 1'b0;
`endif
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_en", {fwd_en, bwd_en}, 0);
    chk("rst_cnt", {sample_idx, epoch_cnt, layer_idx}, 0);
    rst = 1'b0;
    tick();

    // Training run
    start(1'b1, 1'b0);
    chk("tr_mode", mode, 1);
    chk("tr_fwd_c1", fwd_en, 2'b01);
    chk("tr_busy", busy, 1);
    goto(4);  chk("tr_fwd_c4", fwd_en, 2'b01);
    goto(5);  chk("tr_fwd_c5", fwd_en, 2'b10);
    chk("tr_layer_c5", layer_idx, 1);
    goto(8);  chk("tr_fwd_c8", fwd_en, 2'b10);
    goto(9);  chk("tr_bwd_c9", bwd_en, 2'b10);
    chk("tr_fwd_c9", fwd_en, 2'b00);
    goto(12); chk("tr_bwd_c12", bwd_en, 2'b10);
    goto(13); chk("tr_bwd_c13", bwd_en, 2'b01);
    goto(16); chk("tr_bwd_c16", bwd_en, 2'b01);
    goto(17); chk("tr_sample_c17", sample_idx, 1);
    chk("tr_fwd_c17", fwd_en, 2'b01);
    goto(48); chk("tr_done_c48", done, 0);
    goto(49); chk("tr_done_c49", done, 1);
    chk("tr_en_done", {fwd_en, bwd_en}, 0);
    chk("tr_epoch_c49", epoch_cnt, 0);
    goto(50); chk("tr_epoch_c50", epoch_cnt, 1);
    chk("tr_busy_c50", busy, 0);
    chk("tr_done_c50", done, 0);

    // Validation run
    start(1'b0, 1'b1);
    chk("vl_mode", mode, 0);
    bwd_seen = bwd_en;
    while (cyc < 24) begin
      tick();
      bwd_seen |= bwd_en;
      if (cyc == 9) begin
        chk("vl_sample_c9", sample_idx, 1);
        chk("vl_fwd_c9", fwd_en, 2'b01);
      end
    end
    chk("vl_no_bwd", bwd_seen, 0);
    chk("vl_done_c24", done, 0);
    goto(25); chk("vl_done_c25", done, 1);
    goto(26); chk("vl_epoch", epoch_cnt, 1);
    chk("vl_busy_c26", busy, 0);

    // TR+VL together, and TR mid-run ignored
    start(1'b1, 1'b1);
    chk("both_mode", mode, 1);
    goto(3); TR = 1'b1;
    tick();  TR = 1'b0;
    chk("midtr_fwd_c4", fwd_en, 2'b01);
    goto(5); chk("midtr_fwd_c5", fwd_en, 2'b10);
    goto(49); chk("midtr_done_c49", done, 1);
    goto(50); chk("midtr_epoch", epoch_cnt, 2);
    chk("midtr_busy_c50", busy, 0);

    // Halt at cycle 10
    start(1'b1, 1'b0);
    goto(10); halt = 1'b1;
    tick();   halt = 1'b0;
    chk("halt_busy", busy, 0);
    chk("halt_done", done, 0);
    chk("halt_en", {fwd_en, bwd_en}, 0);
    chk("halt_epoch", epoch_cnt, 2);
    chk("halt_sample", sample_idx, 0);
    tick();
    chk("halt_stays_idle", busy, 0);

    // Halt later in the run clears a nonzero sample index
    start(1'b1, 1'b0);
    goto(20); chk("halt2_pre_sample", sample_idx, 1);
    halt = 1'b1;
    tick();   halt = 1'b0;
    chk("halt2_sample", sample_idx, 0);
    chk("halt2_busy", busy, 0);

    // Halt in IDLE blocks a start
    halt = 1'b1; TR = 1'b1;
    tick();
    halt = 1'b0; TR = 1'b0;
    chk("halt_idle_block", busy, 0);

    // Asynchronous reset at cycle 20.5
    start(1'b1, 1'b0);
    goto(20);
    #4 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", {fwd_en, bwd_en}, 0);
    chk("arst_cnt", {sample_idx, epoch_cnt, layer_idx}, 0);
    chk("arst_mode_done", {mode, done}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start(1'b1, 1'b0);
    chk("post_rst_start", busy, 1);
    chk("post_rst_fwd", fwd_en, 2'b01);
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // 255 back-to-back training runs, then one more wraps the epoch count
    for (int i = 0; i < 255; i++) begin
      start(1'b1, 1'b0);
      goto(50);
    end
    chk("epoch_255", epoch_cnt, 8'hff);
    start(1'b1, 1'b0);
    goto(50);
    chk("epoch_wrap", epoch_cnt, 0);

`ifdef MLC_STALL_EN
    // Stall on cycles 3-5 shifts the run by three cycles
    start(1'b1, 1'b0);
    goto(3); stall = 1'b1; #1;
    chk("stall_fwd_c3", fwd_en, 2'b00);
    goto(5); chk("stall_fwd_c5", fwd_en, 2'b00);
    chk("stall_busy", busy, 1);
    tick();  stall = 1'b0; #1;
    chk("stall_fwd_c6", fwd_en, 2'b01);
    goto(7); chk("stall_fwd_c7", fwd_en, 2'b01);
    goto(8); chk("stall_fwd_c8", fwd_en, 2'b10);
    goto(51); chk("stall_done_c51", done, 0);
    goto(52); chk("stall_done_c52", done, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_layer_ctrl.md
MULTI_LAYER_CTRL -- requirements
Module: multi_layer_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_LAYERS, 2, number of network layers sequenced; legal range 2..8.
- PHASE_CYCLES, 4, cycles each layer enable is held; legal range 1..255.
- SAMPLES, 3, samples per run; legal range 1..65535.
- EPOCH_W, 8, epoch counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, asynchronous active-high reset.
- TR, in, 1, train start request, sampled in IDLE.
- VL, in, 1, validate start request, sampled in IDLE.
- halt, in, 1, synchronous abort.
- fwd_en, out, NUM_LAYERS, one-hot forward-propagation enable, bit i = layer i.
- bwd_en, out, NUM_LAYERS, one-hot back-propagation enable.
- layer_idx, out, max(1,$clog2(NUM_LAYERS)), active layer index.
- sample_idx, out, 16, current sample number, 0-based.
- epoch_cnt, out, EPOCH_W, completed training runs.
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle run-complete pulse.
- mode, out, 1, 1 = training, 0 = validation; latched at start.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, FWD, BWD and DONE, all registered.
REQ-004 In IDLE, TR=1 at a posedge SHALL enter FWD with mode=1, layer_idx=0 and sample_idx=0; VL=1 SHALL do the same with mode=0; when TR and VL are both 1, TR SHALL win.
REQ-005 TR and VL SHALL be ignored outside IDLE; there is no queuing.
REQ-006 In FWD, fwd_en SHALL equal one-hot(layer_idx) for exactly PHASE_CYCLES cycles per layer, with layer_idx ascending 0..NUM_LAYERS-1 and no gap cycles between layers.
REQ-007 After FWD layer NUM_LAYERS-1, the FSM SHALL go to BWD starting at layer NUM_LAYERS-1 when mode=1, or end the sample when mode=0.
REQ-008 In BWD, bwd_en SHALL equal one-hot(layer_idx) for PHASE_CYCLES cycles per layer, descending to layer 0.
REQ-009 At sample end, if sample_idx<SAMPLES-1 the FSM SHALL increment sample_idx and return to FWD layer 0 on the next cycle with no gap; otherwise it SHALL enter DONE.
REQ-010 Latency SHALL be 2*NUM_LAYERS*PHASE_CYCLES cycles per training sample and NUM_LAYERS*PHASE_CYCLES cycles per validation sample.
REQ-011 DONE SHALL last one cycle with done=1 and all enables 0, then return to IDLE; epoch_cnt SHALL increment on DONE only when mode=1.
REQ-012 epoch_cnt SHALL wrap modulo 2^EPOCH_W without flagging.
REQ-013 fwd_en and bwd_en SHALL never both be nonzero, and each SHALL be all-zero in IDLE and DONE.
REQ-014 halt=1 in any non-IDLE state SHALL force IDLE at the next posedge, with enables 0, no done pulse, epoch_cnt unchanged and sample_idx cleared.
REQ-015 halt=1 in IDLE SHALL block a start on the same cycle.

Reset
REQ-016 While rst=1, the block SHALL immediately hold state=IDLE, fwd_en=0, bwd_en=0, layer_idx=0, sample_idx=0, epoch_cnt=0, busy=0, done=0 and mode=0, independent of clk.
REQ-017 Reset asserted mid-run SHALL discard all progress; the first start after reset release SHALL be honoured on the first posedge with rst=0.

Configuration
REQ-018 With macro MLC_STALL_EN defined, the block SHALL gain input port stall (1 bit); stall=1 SHALL freeze the state, the phase counter, layer_idx and sample_idx, and SHALL force fwd_en and bwd_en to 0 while it is high.
REQ-019 On stall release, the phase SHALL resume with its remaining cycle count intact.
REQ-020 halt SHALL have priority over stall.
REQ-021 Without MLC_STALL_EN, the stall port and all stall logic SHALL be absent.

Verification
All scenarios use NUM_LAYERS=2, PHASE_CYCLES=4, SAMPLES=3, and a start pulse sampled at posedge 0.
REQ-022 Train run:
- fwd_en=01 on cycles 1-4, 10 on cycles 5-8.
- bwd_en=10 on cycles 9-12, 01 on cycles 13-16.
- sample_idx=1 at cycle 17.
- done on cycle 49, epoch_cnt=1 on cycle 50, busy low on cycle 50.
REQ-023 Validation run (VL): bwd_en is never set, done on cycle 25, epoch_cnt unchanged.
REQ-024 TR and VL both high in IDLE gives mode=1, and a TR pulse during a run is ignored (the second run does not start until after done).
REQ-025 halt on cycle 10 gives IDLE on cycle 11, with no done, epoch_cnt unchanged and sample_idx=0.
REQ-026 rst asserted asynchronously at cycle 20.5 clears all outputs before the next posedge.
REQ-027 With MLC_STALL_EN, stall high on cycles 3-5:
- fwd_en=0 during the stall.
- Layer 0 completes on cycle 7.
- done arrives 3 cycles late, on cycle 52.
- Run 255 training epochs back to back; the next epoch wraps epoch_cnt to 0.
